// File: rtl/slot_alloc_pkg.sv
// slot_alloc_pkg: shared helpers for the free-slot allocator.
// Holds the index/count width functions, default-width typedefs and the
// default slot counts used by the ROB, LSQ and MSHR instantiations.
package slot_alloc_pkg;

    localparam int ROB_WIDTH     = 32;
    localparam int LSQ_WIDTH     = 16;
    localparam int MSHR_WIDTH    = 8;
    localparam int DEFAULT_WIDTH = 8;

    // Bits needed to name one of 'width' slots (at least one bit).
    function automatic int slotIdxWidth(input int width);
        return (width < 2) ? 1 : $clog2(width);
    endfunction

    // Bits needed to hold a count from 0 up to and including 'width'.
    function automatic int slotCntWidth(input int width);
        return $clog2(width + 1);
    endfunction

    typedef logic [slotIdxWidth(DEFAULT_WIDTH)-1:0] slot_idx_t;
    typedef logic [slotCntWidth(DEFAULT_WIDTH)-1:0] slot_cnt_t;

endpackage

// File: rtl/slot_alloc_oneHot2Int.sv
// oneHot2Int: priority encoder from a bitmap to a binary index.
// MODE 0 returns the lowest set bit (trailing-zero count), any other
// MODE returns the highest set bit. empty_o flags an all-zero input,
// in which case cnt_o is 0 and must be ignored by the consumer.
module oneHot2Int
    import slot_alloc_pkg::*;
#(
    parameter  int WIDTH = 8,
    parameter  int MODE  = 0,
    localparam int IW    = slotIdxWidth(WIDTH)
) (
    input  logic [WIDTH-1:0] in_i,
    output logic [IW-1:0]    cnt_o,
    output logic             empty_o
);

    // Scan so the preferred end of the bitmap is visited last and wins.
    always_comb begin
        cnt_o   = '0;
        empty_o = ~|in_i;
        if (MODE == 0) begin
            for (int i = WIDTH - 1; i >= 0; i--) begin
                if (in_i[i]) cnt_o = IW'(i);
            end
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                if (in_i[i]) cnt_o = IW'(i);
            end
        end
    end

endmodule

// File: rtl/slot_alloc.sv
// slot_alloc: free-slot allocator with valid/ready offer of the lowest
// free slot, a single-slot release port and a flush that frees all slots.
// Optional protocol checking is built when SLOT_ALLOC_ERR_EN is defined;
// illegal frees are then flagged on err_o (sticky until reset) and dropped.
module slot_alloc
    import slot_alloc_pkg::*;
#(
    parameter  int WIDTH   = 8,
    parameter  int RESERVE = 0,
    localparam int IW      = slotIdxWidth(WIDTH),
    localparam int CW      = slotCntWidth(WIDTH)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    output logic             alloc_valid_o,
    input  logic             alloc_ready_i,
    output logic [IW-1:0]    alloc_idx_o,
    input  logic             free_valid_i,
    input  logic [IW-1:0]    free_idx_i,
    input  logic             flush_i,
    output logic [WIDTH-1:0] busy_o,
    output logic [CW-1:0]    free_cnt_o,
    output logic             err_o
);

    logic [WIDTH-1:0] r_free;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] w_freeNext;
    logic [CW-1:0]    w_cntNext;
    logic [IW-1:0]    w_allocIdx;
    logic             w_empty;
    logic             w_fire;
    logic             w_freeApply;

    oneHot2Int #(
        .WIDTH (WIDTH),
        .MODE  (0)
    ) u_enc (
        .in_i    (r_free),
        .cnt_o   (w_allocIdx),
        .empty_o (w_empty)
    );

    // The offer depends only on registered state, so consumers may wait on it.
    assign alloc_idx_o   = w_allocIdx;
    assign alloc_valid_o = ~w_empty & (r_cnt > CW'(RESERVE));
    assign w_fire        = alloc_valid_o & alloc_ready_i;
    assign busy_o        = ~r_free;
    assign free_cnt_o    = r_cnt;

`ifdef SLOT_ALLOC_ERR_EN
    logic w_inRange;
    logic w_alreadyFree;
    logic w_collide;
    logic w_illegal;
    logic r_err;

    assign w_inRange     = int'(free_idx_i) < WIDTH;
    assign w_alreadyFree = w_inRange & r_free[free_idx_i];
    assign w_collide     = w_fire & (free_idx_i == w_allocIdx);
    assign w_illegal     = free_valid_i & (~w_inRange | w_alreadyFree | w_collide);
    assign w_freeApply   = free_valid_i & ~w_illegal;
    assign err_o         = r_err;

    // Sticky error flag: only reset clears it, a flush leaves it set.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_err <= 1'b0;
        end else if (w_illegal) begin
            r_err <= 1'b1;
        end
    end
`else
    assign w_freeApply = free_valid_i;
    assign err_o       = 1'b0;
`endif

    // Apply the granted allocation and the release; both may land together.
    always_comb begin
        w_freeNext = r_free;
        if (w_fire) w_freeNext[w_allocIdx] = 1'b0;
        if (w_freeApply) w_freeNext[free_idx_i] = 1'b1;
        w_cntNext = r_cnt - CW'(w_fire) + CW'(w_freeApply);
    end

    // Bitmap and count registers; reset and flush both return every slot.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_free <= '1;
            r_cnt  <= CW'(WIDTH);
        end else if (flush_i) begin
            r_free <= '1;
            r_cnt  <= CW'(WIDTH);
        end else begin
            r_free <= w_freeNext;
            r_cnt  <= w_cntNext;
        end
    end

endmodule
